grant_ctrl: RTL
===============

Name: grant_ctrl

Overview:
Sequential grant controller that sits around the team's combinational fixed-priority arbiter (LSB = highest priority).
- Forwards pending client requests to the arbiter.
- Captures the arbiter's one-hot grant and holds it registered for a client's multi-cycle transfer.
- Releases the grant on client done, request drop, or hold timeout.
- Provides a registered binary index of the granted client for downstream muxing.

Parameters:
N, 8, number of requesting clients (>=2)
MAX_HOLD, 16, maximum grant length in cycles before forced release (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  level requests from clients, bit i = client i
done  in  N  client i asserts for 1 cycle to end its transfer
arb_req  out  N  requests presented to the combinational arbiter
arb_gnt  in  N  one-hot (or zero) grant returned combinationally by the arbiter
gnt  out  N  registered one-hot grant to clients
gnt_idx  out  $clog2(N)  registered binary index of the granted client
gnt_valid  out  1  high while a grant is held
timeout  out  1  1-cycle pulse when a grant is force-released
proto_err  out  1  1-cycle pulse when arb_gnt is illegal

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, proto_err=0, hold counter=0. Reset mid-grant drops the grant immediately, with no timeout pulse.
- Hold counter width: $clog2(MAX_HOLD). It saturates and never wraps.
- FSM states:
  - IDLE:
    - arb_req = req (combinational); arb_req is 0 in every other state.
    - arb_gnt legal (exactly one bit set, and that bit also set in req): next cycle gnt=arb_gnt, gnt_idx=encoded index, gnt_valid=1, counter=0, go GRANT. Grant latency is 1 cycle from the IDLE cycle with req.
    - arb_gnt=0: stay in IDLE.
    - arb_gnt illegal (more than one bit set, or a bit set that is not in req): proto_err pulses next cycle, grant ignored, stay in IDLE.
  - GRANT:
    - gnt/gnt_idx stable. Counter increments each cycle.
    - Release on any of, evaluated each cycle:
      - done[gnt_idx]=1;
      - req[gnt_idx]=0;
      - counter==MAX_HOLD-1.
    - On release, go RELEASE.
    - Timeout priority: if the counter limit and done occur in the same cycle, done wins and timeout is not pulsed.
    - Timeout pulse: for a counter-limit release (no done), timeout=1 during the RELEASE cycle.
    - done/req bits of non-granted clients are ignored.
  - RELEASE: gnt=0, gnt_valid=0, gnt_idx holds its last value. Unconditionally go to IDLE next cycle. This guarantees at least one dead cycle between grants.
- Maximum grant length: exactly MAX_HOLD cycles of gnt_valid=1.
- Grant-to-grant spacing: minimum 3 cycles (GRANT → RELEASE → IDLE → GRANT).
- Registered outputs: all outputs except arb_req are registered, with no combinational path from req/done to gnt.

Optional Feature:
Macro GRANT_CTRL_FAIR_EN.
- Defined:
  - A last-served register (N bits, reset 0) records the one-hot client of the most recently released grant.
  - In IDLE, arb_req = req & ~last_served when (req & ~last_served) != 0; otherwise arb_req = req.
  - This prevents the fixed-priority arbiter from starving higher-index clients on back-to-back requests.
  - The legality check for arb_gnt uses the masked arb_req.
- Not defined: no mask register; arb_req = req in IDLE. Pure fixed priority.

Test Plan:
- Reset, then req=8'b0000_0110, arb_gnt=8'b0000_0010 → next cycle gnt=8'b0000_0010, gnt_idx=1, gnt_valid=1; arb_req=0 while in GRANT.
- Grant to client 1, done[1] pulsed 4 cycles later → gnt_valid high 5 cycles, one RELEASE cycle with gnt=0, timeout=0, IDLE next.
- MAX_HOLD=16, client 3 holds req with no done → gnt_valid high exactly 16 cycles, timeout=1 for one cycle, then re-arbitration.
- arb_gnt=8'b0000_0011 with req=8'b0000_0011 in IDLE → proto_err pulse, gnt stays 0, FSM stays in IDLE.
- rst_n asserted low mid-GRANT (asynchronous, between clock edges) → gnt=0, gnt_valid=0 immediately; no timeout pulse after reset release.
- GRANT_CTRL_FAIR_EN defined, req=8'b0000_0101 held, clients release via done → arb_req alternates 8'b0000_0100 / 8'b0000_0001 on successive IDLE cycles, grants alternate idx 2 / idx 0.

Source files
------------

// File: rtl/grant_ctrl_if.sv
// -----------------------------------------------------------------------------
// grant_ctrl_if
//   Bundle of the client-facing and arbiter-facing signals of grant_ctrl.
//
//   Parameter:
//     N          number of requesting clients
//
//   Signals:
//     req        client level requests, bit i = client i
//     done       client i pulses for one cycle to end its transfer
//     arb_req    requests presented to the combinational arbiter
//     arb_gnt    one-hot (or zero) grant returned by the arbiter
//     gnt        registered one-hot grant to clients
//     gnt_idx    registered binary index of the granted client
//     gnt_valid  high while a grant is held
//     timeout    one-cycle pulse on a forced (hold-limit) release
//     proto_err  one-cycle pulse when arb_gnt was illegal
//
//   Modports:
//     slave      the grant controller itself
//     master     the environment (clients plus arbiter) around it
// -----------------------------------------------------------------------------
interface grant_ctrl_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic [N-1:0]     arb_req;
  logic [N-1:0]     arb_gnt;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  logic             proto_err;

  modport slave (
    input  req, done, arb_gnt,
    output arb_req, gnt, gnt_idx, gnt_valid, timeout, proto_err
  );

  modport master (
    output req, done, arb_gnt,
    input  arb_req, gnt, gnt_idx, gnt_valid, timeout, proto_err
  );
endinterface

// File: rtl/grant_ctrl.sv
// -----------------------------------------------------------------------------
// grant_ctrl
//   Sequential wrapper around an external combinational fixed-priority arbiter
//   (LSB = highest priority). In IDLE it forwards pending requests to the
//   arbiter, captures a legal one-hot grant, holds it registered for the
//   client's multi-cycle transfer and releases it on done, request drop or
//   hold timeout. Every release is followed by one dead RELEASE cycle.
//
//   Parameters:
//     N          number of requesting clients (>= 2)
//     MAX_HOLD   maximum grant length in cycles before forced release (>= 2)
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        grant_ctrl_if.slave (req, done, arb_gnt in;
//                arb_req, gnt, gnt_idx, gnt_valid, timeout, proto_err out)
//
//   Optional feature (macro GRANT_CTRL_FAIR_EN):
//     Defined   : the client released most recently is masked out of arb_req
//                 while any other client is requesting, so back-to-back
//                 requests alternate instead of the lowest index winning.
//     Undefined : arb_req = req in IDLE, pure fixed priority.
//
//   All outputs except arb_req are registered; there is no combinational path
//   from req/done to gnt.
// -----------------------------------------------------------------------------
module grant_ctrl #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic        clk,
  input logic        rst_n,
  grant_ctrl_if.slave bus
);

  localparam int                IDX_W     = $clog2(N);
  localparam int                CNT_W     = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_HOLD - 1);
  localparam logic [N-1:0]      LSB_ONE   = N'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Requests the arbiter sees while IDLE; also the reference for legality.
  logic [N-1:0]     req_eff;

`ifdef GRANT_CTRL_FAIR_EN
  logic [N-1:0] last_served_q, last_served_d;
  logic [N-1:0] req_masked;

  // Fall back to the unmasked requests when only the last-served client is
  // asking, otherwise it would never be granted again.
  always_comb begin
    req_masked = bus.req & ~last_served_q;
    req_eff    = (req_masked != '0) ? req_masked : bus.req;
  end
`else
  assign req_eff = bus.req;
`endif

  assign bus.arb_req = (state_q == IDLE) ? req_eff : '0;

  // Legal grant: exactly one bit set, and that bit was actually requested.
  logic arb_onehot;
  logic arb_legal;

  assign arb_onehot = (bus.arb_gnt != '0) &&
                      ((bus.arb_gnt & (bus.arb_gnt - LSB_ONE)) == '0);
  assign arb_legal  = arb_onehot && ((bus.arb_gnt & ~req_eff) == '0);

  function automatic logic [IDX_W-1:0] encode(input logic [N-1:0] onehot);
    encode = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) encode = IDX_W'(i);
    end
  endfunction

  // Only the granted client's done/req matter while a grant is held.
  logic done_sel;
  logic req_sel;
  logic at_limit;

  assign done_sel = bus.done[idx_q];
  assign req_sel  = bus.req[idx_q];
  assign at_limit = (cnt_q == CNT_LIMIT);

  // NOTE: every signal written here gets its default first, so no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    timeout_d     = 1'b0;
    proto_err_d   = 1'b0;
    cnt_d         = cnt_q;
`ifdef GRANT_CTRL_FAIR_EN
    last_served_d = last_served_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.arb_gnt != '0) begin
          if (arb_legal) begin
            gnt_d   = bus.arb_gnt;
            idx_d   = encode(bus.arb_gnt);
            valid_d = 1'b1;
            state_d = GRANT;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end

      GRANT: begin
        // Saturating: the limit forces a release before a wrap could occur.
        cnt_d = at_limit ? cnt_q : cnt_q + CNT_W'(1);
        if (done_sel || !req_sel || at_limit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          // A done arriving on the limit cycle is a normal completion.
          timeout_d = at_limit && !done_sel;
`ifdef GRANT_CTRL_FAIR_EN
          last_served_d = gnt_q;
`endif
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef GRANT_CTRL_FAIR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_served_q <= '0;
    else        last_served_q <= last_served_d;
  end
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.proto_err = proto_err_q;

endmodule
